// File: rtl/ecc_scrub_scheduler.sv
// Bank of Hamming(7,4)-protected counters with round-robin increment arbitration,
// a periodic background scrubber that corrects single-bit errors, and test-only fault injection.
module ecc_scrub_scheduler #(
  parameter int WIDTH        = 32,
  parameter int BLOCKS       = WIDTH / 4,
  parameter int PARITY_BITS  = BLOCKS * 3,
  parameter int NUM_CNT      = 4,
  parameter int SCRUB_PERIOD = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CNT-1:0]         inc_req,
  output logic [NUM_CNT-1:0]         inc_gnt,
  input  logic                       scrub_en,
  input  logic                       inj_valid,
  input  logic [$clog2(NUM_CNT)-1:0] inj_sel,
  input  logic [$clog2(WIDTH)-1:0]   inj_bit,
  input  logic [$clog2(NUM_CNT)-1:0] rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       scrub_busy,
  output logic                       err_irq,
  output logic [$clog2(NUM_CNT)-1:0] err_idx,
  output logic [15:0]                corr_count
);

  localparam int PTR_W = $clog2(NUM_CNT);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int TMR_W = $clog2(SCRUB_PERIOD + 1);

  localparam logic [PTR_W:0]   NUM_CNT_L = (PTR_W + 1)'(NUM_CNT);
  localparam logic [BIT_W:0]   WIDTH_L   = (BIT_W + 1)'(WIDTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_CNT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SCRUB_PERIOD - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SCRUB_CHK = 2'd1;
  localparam logic [1:0] SCRUB_FIX = 2'd2;

  function automatic logic [PARITY_BITS-1:0] calc_parity(input logic [WIDTH-1:0] d);
    logic [PARITY_BITS-1:0] p;
    p = {PARITY_BITS{1'b0}};
    for (int i = 0; i < BLOCKS; i++) begin
      p[i*3+0] = d[i*4+0] ^ d[i*4+2] ^ d[i*4+3];
      p[i*3+1] = d[i*4+0] ^ d[i*4+1] ^ d[i*4+3];
      p[i*3+2] = d[i*4+0] ^ d[i*4+1] ^ d[i*4+2];
    end
    return p;
  endfunction

  // Syndromes that name a parity bit alone leave the data untouched.
  function automatic logic [WIDTH-1:0] correct_data(input logic [WIDTH-1:0]       d,
                                                    input logic [PARITY_BITS-1:0] syn);
    logic [WIDTH-1:0] c;
    c = d;
    for (int i = 0; i < BLOCKS; i++) begin
      case (syn[i*3 +: 3])
        3'b011:  c[i*4+3] = ~c[i*4+3];
        3'b101:  c[i*4+2] = ~c[i*4+2];
        3'b110:  c[i*4+1] = ~c[i*4+1];
        3'b111:  c[i*4+0] = ~c[i*4+0];
        default: c = c;
      endcase
    end
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0]       data_r [NUM_CNT];
  logic [PARITY_BITS-1:0] par_r  [NUM_CNT];
  logic [1:0]             state_r;
  logic [TMR_W-1:0]       timer_r;
  logic [PTR_W-1:0]       scrub_ptr_r;
  logic [PTR_W-1:0]       rr_ptr_r;
  logic [PTR_W-1:0]       err_idx_r;
  logic [15:0]            corr_count_r;

  logic                   gnt_found_s;
  logic [PTR_W-1:0]       gnt_idx_s;
  logic                   gnt_valid_s;
  logic [WIDTH-1:0]       inc_data_s;
  logic [PARITY_BITS-1:0] inc_par_s;
  logic [WIDTH-1:0]       cur_data_s;
  logic [PARITY_BITS-1:0] syn_s;
  logic [WIDTH-1:0]       fix_data_s;
  logic [PARITY_BITS-1:0] fix_par_s;
  logic                   inj_ok_s;

  // Round-robin search: first requester at or after rr_ptr_r.
  always_comb begin
    logic [PTR_W:0] cand_v;
    cand_v      = {(PTR_W + 1){1'b0}};
    gnt_found_s = 1'b0;
    gnt_idx_s   = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      cand_v = {1'b0, rr_ptr_r} + (PTR_W + 1)'(i);
      if (cand_v >= NUM_CNT_L) begin
        cand_v = cand_v - NUM_CNT_L;
      end else begin
        cand_v = cand_v;
      end
      if (!gnt_found_s && inc_req[cand_v[PTR_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_v[PTR_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Datapath: increment value, scrub syndrome/correction and injection qualification.
  always_comb begin
    gnt_valid_s = gnt_found_s && reset && (state_r == IDLE);
    inc_data_s  = data_r[gnt_idx_s] + WIDTH'(1);
    inc_par_s   = calc_parity(inc_data_s);
    cur_data_s  = data_r[scrub_ptr_r];
    syn_s       = par_r[scrub_ptr_r] ^ calc_parity(cur_data_s);
    fix_data_s  = correct_data(cur_data_s, syn_s);
    fix_par_s   = calc_parity(fix_data_s);
    inj_ok_s    = reset && inj_valid
                  && ({1'b0, inj_sel} < NUM_CNT_L)
                  && ({1'b0, inj_bit} < WIDTH_L)
                  && !(gnt_valid_s && (gnt_idx_s == inj_sel))
                  && !((state_r == SCRUB_FIX) && (scrub_ptr_r == inj_sel));
  end

  // Grant vector and raw readback.
  always_comb begin
    inc_gnt = {NUM_CNT{1'b0}};
    if (gnt_valid_s) begin
      inc_gnt[gnt_idx_s] = 1'b1;
    end else begin
      inc_gnt = {NUM_CNT{1'b0}};
    end
    if ({1'b0, rd_sel} < NUM_CNT_L) begin
      rd_data = data_r[rd_sel];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  // Counter storage: increments, scrub write-back and injected faults never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
        par_r[i]  <= {PARITY_BITS{1'b0}};
      end
    end else begin
      if (gnt_valid_s) begin
        data_r[gnt_idx_s] <= inc_data_s;
        par_r[gnt_idx_s]  <= inc_par_s;
      end
      if (state_r == SCRUB_FIX) begin
        data_r[scrub_ptr_r] <= fix_data_s;
        par_r[scrub_ptr_r]  <= fix_par_s;
      end
      if (inj_ok_s) begin
        data_r[inj_sel][inj_bit] <= ~data_r[inj_sel][inj_bit];
      end
    end
  end

  // Scrub FSM, scrub timer, arbitration pointer and correction bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      timer_r      <= {TMR_W{1'b0}};
      scrub_ptr_r  <= {PTR_W{1'b0}};
      rr_ptr_r     <= {PTR_W{1'b0}};
      err_idx_r    <= {PTR_W{1'b0}};
      corr_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (scrub_en) begin
            if (timer_r == TMR_LAST) begin
              timer_r <= {TMR_W{1'b0}};
              state_r <= SCRUB_CHK;
            end else begin
              timer_r <= timer_r + TMR_W'(1);
            end
          end
        end
        SCRUB_CHK: begin
          if (syn_s != {PARITY_BITS{1'b0}}) begin
            state_r <= SCRUB_FIX;
          end else begin
            scrub_ptr_r <= next_ptr(scrub_ptr_r);
            state_r     <= IDLE;
          end
        end
        SCRUB_FIX: begin
          err_idx_r   <= scrub_ptr_r;
          scrub_ptr_r <= next_ptr(scrub_ptr_r);
          state_r     <= IDLE;
          if (corr_count_r != 16'hFFFF) begin
            corr_count_r <= corr_count_r + 16'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (gnt_valid_s) begin
        rr_ptr_r <= next_ptr(gnt_idx_s);
      end
    end
  end

  assign scrub_busy = reset && ((state_r == SCRUB_CHK) || (state_r == SCRUB_FIX));
  assign err_irq    = reset && (state_r == SCRUB_FIX);
  assign err_idx    = err_idx_r;
  assign corr_count = corr_count_r;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Bench for ecc_scrub_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the counter bank and scrubber.
module tb_ecc_scrub_scheduler;

  localparam int WIDTH   = 32;
  localparam int NUM_CNT = 4;
  localparam int PERIOD  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  inc_req;
  logic [3:0]  inc_gnt;
  logic        scrub_en;
  logic        inj_valid;
  logic [1:0]  inj_sel;
  logic [4:0]  inj_bit;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data;
  logic        scrub_busy;
  logic        err_irq;
  logic [1:0]  err_idx;
  logic [15:0] corr_count;

  always #5 clk = ~clk;

  ecc_scrub_scheduler #(.WIDTH(WIDTH), .NUM_CNT(NUM_CNT), .SCRUB_PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .inc_req(inc_req), .inc_gnt(inc_gnt), .scrub_en(scrub_en),
    .inj_valid(inj_valid), .inj_sel(inj_sel), .inj_bit(inj_bit), .rd_sel(rd_sel),
    .rd_data(rd_data), .scrub_busy(scrub_busy), .err_irq(err_irq), .err_idx(err_idx),
    .corr_count(corr_count)
  );

  // Model: phase 0 = idle, 1 = checking, 2 = fixing.
  logic [31:0] m_data [4];
  logic [23:0] m_par  [4];
  int m_phase, m_timer, m_sptr, m_rr, m_eidx, m_corr;
  int errors = 0;
  int checks = 0;
  int flip_pos [8] = '{-1, -1, -1, 3, -1, 2, 1, 0};

  function automatic logic [23:0] m_parity(input logic [31:0] d);
    logic [23:0] p;
    logic [3:0]  n;
    p = 24'd0;
    for (int b = 0; b < 8; b++) begin
      n = d[4*b +: 4];
      p[3*b+0] = n[0] ^ n[2] ^ n[3];
      p[3*b+1] = n[0] ^ n[1] ^ n[3];
      p[3*b+2] = n[0] ^ n[1] ^ n[2];
    end
    return p;
  endfunction

  function automatic logic [31:0] m_fix(input logic [31:0] d, input logic [23:0] syn);
    logic [31:0] c;
    int pos;
    c = d;
    for (int b = 0; b < 8; b++) begin
      pos = flip_pos[syn[3*b +: 3]];
      if (pos >= 0) c[4*b + pos] = ~c[4*b + pos];
    end
    return c;
  endfunction

  function automatic int m_winner();
    int idx;
    if (!reset || m_phase != 0) return -1;
    for (int k = 0; k < NUM_CNT; k++) begin
      idx = (m_rr + k) % NUM_CNT;
      if (inc_req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int w;
    logic [3:0] eg;
    w  = m_winner();
    eg = 4'd0;
    if (w >= 0) eg[w] = 1'b1;
    check("inc_gnt", {28'd0, inc_gnt}, {28'd0, eg});
    check("scrub_busy", {31'd0, scrub_busy}, {31'd0, (reset && m_phase != 0)});
    check("err_irq", {31'd0, err_irq}, {31'd0, (reset && m_phase == 2)});
    check("err_idx", {30'd0, err_idx}, 32'(m_eidx));
    check("corr_count", {16'd0, corr_count}, 32'(m_corr));
    check("rd_data", rd_data, m_data[rd_sel]);
  endtask

  task automatic model_step();
    int w, sp_old;
    logic fixing;
    logic [23:0] syn;
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin m_data[i] = 32'd0; m_par[i] = 24'd0; end
      m_phase = 0; m_timer = 0; m_sptr = 0; m_rr = 0; m_eidx = 0; m_corr = 0;
      return;
    end
    w = m_winner();
    sp_old = m_sptr;
    fixing = (m_phase == 2);
    syn = m_par[sp_old] ^ m_parity(m_data[sp_old]);
    if (m_phase == 0) begin
      if (scrub_en) begin
        if (m_timer == PERIOD - 1) begin m_timer = 0; m_phase = 1; end
        else m_timer++;
      end
    end else if (m_phase == 1) begin
      if (syn != 24'd0) m_phase = 2;
      else begin m_sptr = (m_sptr + 1) % NUM_CNT; m_phase = 0; end
    end else begin
      m_data[sp_old] = m_fix(m_data[sp_old], syn);
      m_par[sp_old]  = m_parity(m_data[sp_old]);
      m_eidx = sp_old;
      if (m_corr < 65535) m_corr++;
      m_sptr = (m_sptr + 1) % NUM_CNT;
      m_phase = 0;
    end
    if (w >= 0) begin
      m_data[w] = m_data[w] + 32'd1;
      m_par[w]  = m_parity(m_data[w]);
      m_rr = (w + 1) % NUM_CNT;
    end
    if (inj_valid && (int'(inj_sel) != w) && !(fixing && int'(inj_sel) == sp_old))
      m_data[inj_sel][inj_bit] = ~m_data[inj_sel][inj_bit];
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1 compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inc_req = 4'd0; scrub_en = 1'b0; inj_valid = 1'b0;
    inj_sel = 2'd0; inj_bit = 5'd0; rd_sel = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic run_until_phase(input int ph, input int budget, input string name);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin cycle(); n++; end
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles waiting for phase %0d", name, n, ph);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    do_reset();
    #1 check("reset_corr", {16'd0, corr_count}, 32'd0);
    check("reset_rd", rd_data, 32'd0);

    // Round-robin with all requesters active.
    inc_req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", {28'd0, inc_gnt}, 32'(4'b0001 << (k % 4)));
      cycle();
    end
    inc_req = 4'd0;
    for (int c = 0; c < 4; c++) begin
      rd_sel = 2'(c);
      #1 check("rr_value", rd_data, 32'd2);
      cycle();
    end

    // Injection collides with an increment of the same counter.
    do_reset();
    inc_req = 4'b1000; inj_valid = 1'b1; inj_sel = 2'd3; inj_bit = 5'd0;
    cycle();
    inc_req = 4'd0; inj_valid = 1'b0; rd_sel = 2'd3;
    #1 check("inj_conflict", rd_data, 32'd1);
    scrub_en = 1'b1;
    for (int k = 0; k < 80; k++) cycle();
    #1 check("conflict_no_err", {16'd0, corr_count}, 32'd0);

    // Single-bit correction on counter 2.
    scrub_en = 1'b0;
    run_until_phase(0, 10, "idle_before_inc");
    inc_req = 4'b0100;
    for (int k = 0; k < 5; k++) cycle();
    inc_req = 4'd0; inj_valid = 1'b1; inj_sel = 2'd2; inj_bit = 5'd9;
    cycle();
    inj_valid = 1'b0; rd_sel = 2'd2;
    #1 check("inj_flip", rd_data, 32'h205);
    scrub_en = 1'b1;
    run_until_phase(2, 200, "reach_fix");
    #1 check("fix_irq", {31'd0, err_irq}, 32'd1);
    cycle();
    #1 check("fixed_data", rd_data, 32'h5);
    check("fixed_idx", {30'd0, err_idx}, 32'd2);
    check("fixed_count", {16'd0, corr_count}, 32'd1);

    // Request held across a scrub that needs a fix.
    run_until_phase(0, 10, "idle_before_hold");
    inj_valid = 1'b1; inj_sel = 2'(m_sptr); inj_bit = 5'd4;
    cycle();
    inj_valid = 1'b0;
    run_until_phase(1, 200, "reach_chk");
    inc_req = 4'b0001;
    #1 check("hold_gnt_chk", {28'd0, inc_gnt}, 32'd0);
    cycle();
    #1 check("hold_gnt_fix", {28'd0, inc_gnt}, 32'd0);
    check("hold_busy_fix", {31'd0, scrub_busy}, 32'd1);
    cycle();
    #1 check("hold_gnt_idle", {28'd0, inc_gnt}, 32'd1);
    cycle();
    inc_req = 4'd0;

    // Wrap of counter 1: build 0xFFFFFFFE by injection, then two increments.
    scrub_en = 1'b0;
    run_until_phase(0, 10, "idle_before_wrap");
    inj_sel = 2'd1;
    for (int b = 1; b < 32; b++) begin
      inj_valid = 1'b1; inj_bit = 5'(b);
      cycle();
    end
    inj_valid = 1'b0; rd_sel = 2'd1;
    #1 check("wrap_pre", rd_data, 32'hFFFF_FFFE);
    inc_req = 4'b0010;
    cycle();
    #1 check("wrap_max", rd_data, 32'hFFFF_FFFF);
    cycle();
    inc_req = 4'd0;
    #1 check("wrap_zero", rd_data, 32'h0);
    scrub_en = 1'b1;
    for (int k = 0; k < 80; k++) cycle();
    #1 check("wrap_no_err", {16'd0, corr_count}, 32'd2);

    // Reset during SCRUB_FIX aborts the write.
    run_until_phase(0, 10, "idle_before_abort");
    inj_valid = 1'b1; inj_sel = 2'd0; inj_bit = 5'd1;
    cycle();
    inj_valid = 1'b0;
    run_until_phase(2, 200, "reach_fix_abort");
    reset = 1'b0;
    cycle();
    reset = 1'b1; rd_sel = 2'd0;
    #1 check("abort_corr", {16'd0, corr_count}, 32'd0);
    check("abort_busy", {31'd0, scrub_busy}, 32'd0);
    check("abort_data", rd_data, 32'd0);
    cycle();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 99) != 0);
      inc_req   = 4'($urandom_range(0, 15));
      scrub_en  = ($urandom_range(0, 9) != 0);
      inj_valid = ($urandom_range(0, 19) == 0);
      inj_sel   = 2'($urandom_range(0, 3));
      inj_bit   = 5'($urandom_range(0, 31));
      rd_sel    = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
